// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file for the execute stage.
// Storage has no reset; a hardware sequencer zeroes it after reset or on request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | clr_idx walks the array writing zeros; ports are blocked
// S_RUN   | normal operation: writes commit, reads return data
module regfile_mp #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 1,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = (NREGS <= 2) ? 1 : $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   i_wr_data,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*XLEN-1:0]   o_rd_data,
  input  logic                     i_clear,
  output logic                     o_ready,
  output logic [NREGS*XLEN-1:0]    d_regs_out
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Register 0 is hardwired when ZERO_REG, so the sweep skips it.
  localparam logic [AW-1:0] START_IDX = AW'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic          RST_READY = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

  state_t          r_state;
  logic [AW-1:0]   r_clr_idx;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREGS];

  // Out-of-range addresses (non power-of-two depth) and the hardwired zero are invalid.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    addr_valid = (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Sequencer: clear sweep and run/clear handshake; o_ready is registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= RST_STATE;
      r_clr_idx <= START_IDX;
      r_ready   <= RST_READY;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state   <= S_RUN;
            r_clr_idx <= START_IDX;
            r_ready   <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        S_RUN: begin
          if (i_clear) begin
            r_state <= S_CLEAR;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clear sweep has the array to itself; otherwise the
  // highest-numbered enabled port wins because its assignment lands last.
  always_ff @(posedge i_clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_wr_en[k] && addr_valid(i_wr_addr[k*AW +: AW])) begin
          r_mem[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_val;

    assign w_addr = i_rd_addr[j*AW +: AW];

    // Read mux: masked while clearing or for invalid addresses, then
    // storage, then optional same-cycle bypass with write-port priority.
    always_comb begin
      w_val = '0;
      if ((r_state == S_RUN) && addr_valid(w_addr)) begin
        w_val = r_mem[w_addr];
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == w_addr)) begin
              w_val = i_wr_data[k*XLEN +: XLEN];
            end
          end
        end
      end
    end

    assign o_rd_data[j*XLEN +: XLEN] = w_val;
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_dbg
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign d_regs_out[r*XLEN +: XLEN] = '0;
    end else begin : g_store
      assign d_regs_out[r*XLEN +: XLEN] = r_mem[r];
    end
  end

  assign o_ready = r_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (A: 32 regs, bypass, clear on reset;
// B: 24 regs, no bypass, no clear on reset), both with two write ports.
module tb_regfile_mp;

  localparam int AW = 5;

  logic        clk;
  int          total;
  int          bad;

  logic        a_rst, a_clear, a_ready;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr, a_rd_addr;
  logic [63:0] a_wr_data, a_rd_data;
  logic [32*32-1:0] a_regs;

  logic        b_rst, b_clear, b_ready;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr, b_rd_addr;
  logic [63:0] b_wr_data, b_rd_data;
  logic [24*32-1:0] b_regs;

  logic [31:0] ma [32];
  logic [31:0] mb [24];
  bit          a_run_m, b_run_m;

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1),
               .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
    .i_wr_data(a_wr_data), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .i_clear(a_clear), .o_ready(a_ready), .d_regs_out(a_regs));

  regfile_mp #(.XLEN(32), .NREGS(24), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1),
               .BYPASS(0), .CLEAR_ON_RESET(0)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
    .i_wr_data(b_wr_data), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .i_clear(b_clear), .o_ready(b_ready), .d_regs_out(b_regs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read for A in RUN: zero for x0, else the last enabled writer of
  // that address this cycle, else the architectural value.
  function automatic logic [31:0] exp_a(input logic [4:0] ra);
    logic [31:0] v;
    if (ra == 5'd0) return 32'h0;
    v = ma[ra];
    for (int k = 0; k < 2; k++)
      if (a_wr_en[k] && a_wr_addr[k*AW +: AW] == ra) v = a_wr_data[k*32 +: 32];
    return v;
  endfunction

  // Expected read for B in RUN: no bypass, 24 registers, x0 hardwired.
  function automatic logic [31:0] exp_b(input logic [4:0] ra);
    if (ra == 5'd0 || int'(ra) >= 24) return 32'h0;
    return mb[ra];
  endfunction

  function automatic logic [24*32-1:0] model_b_vec();
    logic [24*32-1:0] v;
    for (int r = 0; r < 24; r++) v[r*32 +: 32] = mb[r];
    return v;
  endfunction

  function automatic logic [32*32-1:0] model_a_vec();
    logic [32*32-1:0] v;
    for (int r = 0; r < 32; r++) v[r*32 +: 32] = ma[r];
    return v;
  endfunction

  // Advance one clock; the models commit whatever the ports drive this edge.
  task automatic tick();
    @(posedge clk);
    if (a_run_m)
      for (int k = 0; k < 2; k++)
        if (a_wr_en[k] && a_wr_addr[k*AW +: AW] != 5'd0)
          ma[a_wr_addr[k*AW +: AW]] = a_wr_data[k*32 +: 32];
    if (b_run_m)
      for (int k = 0; k < 2; k++)
        if (b_wr_en[k] && b_wr_addr[k*AW +: AW] != 5'd0 && int'(b_wr_addr[k*AW +: AW]) < 24)
          mb[b_wr_addr[k*AW +: AW]] = b_wr_data[k*32 +: 32];
    #1;
  endtask

  task automatic test_reset();
    int  lows;
    bit  done;
    lows = 0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      a_rd_addr = 10'($urandom);
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (b_ready !== 1'b1) begin
          bad++;
          $display("FAIL b_ready_after_reset got=%b want=1", b_ready);
        end
      end
      if (a_ready === 1'b1) done = 1;
      else begin
        lows++;
        total++;
        if (a_rd_data !== 64'h0) begin
          bad++;
          $display("FAIL a_rd_during_clear cyc=%0d got=%h want=0", c, a_rd_data);
        end
      end
      tick();
    end
    total++;
    if (!done || lows != 31) begin
      bad++;
      $display("FAIL a_reset_clear_len got=%0d want=31 done=%0b", lows, done);
    end
    for (int r = 0; r < 32; r++) ma[r] = 32'h0;
    a_run_m = 1;
    total++;
    if (a_regs !== '0) begin
      bad++;
      $display("FAIL a_regs_after_clear got=%h want=0", a_regs);
    end
  endtask

  task automatic test_clear_b();
    int lows;
    bit done;
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    b_run_m = 0;
    lows = 0;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      b_wr_en   = (c < 15) ? 2'b11 : 2'b00;
      b_wr_addr = {5'd9, 5'd5};
      b_wr_data = {$urandom, $urandom};
      b_clear   = (c >= 5 && c <= 7);
      b_rd_addr = {5'd9, 5'd5};
      @(negedge clk);
      if (b_ready === 1'b1) begin
        done = 1;
        b_wr_en = 2'b00;
        b_clear = 1'b0;
        for (int r = 0; r < 24; r++) mb[r] = 32'h0;
        b_run_m = 1;
      end else begin
        lows++;
        total++;
        if (b_rd_data !== 64'h0) begin
          bad++;
          $display("FAIL b_rd_during_clear cyc=%0d got=%h want=0", c, b_rd_data);
        end
      end
      tick();
    end
    total++;
    if (!done || lows != 23) begin
      bad++;
      $display("FAIL b_clear_len got=%0d want=23 done=%0b", lows, done);
    end
    total++;
    if (b_regs !== '0) begin
      bad++;
      $display("FAIL b_regs_after_clear got=%h want=0", b_regs);
    end
  endtask

  task automatic test_bypass();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
    a_rd_addr = {5'd6, 5'd5};
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd5}; b_wr_data = {32'h0, 32'hDEADBEEF};
    b_rd_addr = {5'd6, 5'd5};
    @(negedge clk);
    total++;
    if (a_rd_data !== {32'h0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL a_bypass_same_cycle got=%h want=%h", a_rd_data, {32'h0, 32'hDEADBEEF});
    end
    total++;
    if (b_rd_data[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL b_nobypass_same_cycle got=%h want=0", b_rd_data[31:0]);
    end
    tick();
    a_wr_en = 2'b00;
    b_wr_en = 2'b00;
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL a_write_next_cycle got=%h want=deadbeef", a_rd_data[31:0]);
    end
    total++;
    if (b_rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL b_write_next_cycle got=%h want=deadbeef", b_rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_conflict();
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h22, 32'h11};
    a_rd_addr = {5'd7, 5'd7};
    b_wr_en = 2'b11; b_wr_addr = {5'd7, 5'd7}; b_wr_data = {32'h22, 32'h11};
    b_rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    total++;
    if (a_rd_data !== {32'h22, 32'h22}) begin
      bad++;
      $display("FAIL a_conflict_bypass got=%h want=%h", a_rd_data, {32'h22, 32'h22});
    end
    tick();
    a_wr_en = 2'b00;
    b_wr_en = 2'b00;
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'h22 || a_regs[7*32 +: 32] !== 32'h22) begin
      bad++;
      $display("FAIL a_conflict_commit got=%h/%h want=22", a_rd_data[31:0], a_regs[7*32 +: 32]);
    end
    total++;
    if (b_rd_data[31:0] !== 32'h22 || b_regs[7*32 +: 32] !== 32'h22) begin
      bad++;
      $display("FAIL b_conflict_commit got=%h/%h want=22", b_rd_data[31:0], b_regs[7*32 +: 32]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    a_wr_en = 2'b10; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h1234, 32'h0};
    a_rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    total++;
    if (a_rd_data !== 64'h0) begin
      bad++;
      $display("FAIL a_x0_same_cycle got=%h want=0", a_rd_data);
    end
    tick();
    a_wr_en = 2'b00;
    @(negedge clk);
    total++;
    if (a_rd_data !== 64'h0 || a_regs[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL a_x0_after got=%h dbg=%h want=0", a_rd_data, a_regs[31:0]);
    end
    tick();
  endtask

  task automatic test_invalid_addr();
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd30}; b_wr_data = {32'h0, 32'hCAFEF00D};
    b_rd_addr = {5'd30, 5'd30};
    @(negedge clk);
    total++;
    if (b_rd_data !== 64'h0) begin
      bad++;
      $display("FAIL b_invalid_read got=%h want=0", b_rd_data);
    end
    tick();
    b_wr_en = 2'b00;
    @(negedge clk);
    total++;
    if (b_rd_data !== 64'h0 || b_regs !== model_b_vec()) begin
      bad++;
      $display("FAIL b_invalid_write_dropped rd=%h", b_rd_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] ra;
    for (int c = 0; c < 400; c++) begin
      a_wr_en = 2'($urandom); a_wr_addr = 10'($urandom); a_wr_data = {$urandom, $urandom};
      b_wr_en = 2'($urandom); b_wr_addr = 10'($urandom); b_wr_data = {$urandom, $urandom};
      for (int j = 0; j < 2; j++) begin
        ra = ($urandom_range(0, 2) == 0) ? a_wr_addr[j*AW +: AW] : 5'($urandom);
        a_rd_addr[j*AW +: AW] = ra;
        ra = ($urandom_range(0, 2) == 0) ? b_wr_addr[j*AW +: AW] : 5'($urandom);
        b_rd_addr[j*AW +: AW] = ra;
      end
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        total++;
        if (a_rd_data[j*32 +: 32] !== exp_a(a_rd_addr[j*AW +: AW])) begin
          bad++;
          $display("FAIL a_rand_rd c=%0d p=%0d addr=%0d got=%h want=%h", c, j,
                   a_rd_addr[j*AW +: AW], a_rd_data[j*32 +: 32], exp_a(a_rd_addr[j*AW +: AW]));
        end
        total++;
        if (b_rd_data[j*32 +: 32] !== exp_b(b_rd_addr[j*AW +: AW])) begin
          bad++;
          $display("FAIL b_rand_rd c=%0d p=%0d addr=%0d got=%h want=%h", c, j,
                   b_rd_addr[j*AW +: AW], b_rd_data[j*32 +: 32], exp_b(b_rd_addr[j*AW +: AW]));
        end
      end
      if (c % 50 == 49) begin
        total++;
        if (a_regs !== model_a_vec() || b_regs !== model_b_vec()) begin
          bad++;
          $display("FAIL rand_regs_view c=%0d", c);
        end
      end
      tick();
    end
    a_wr_en = 2'b00;
    b_wr_en = 2'b00;
  endtask

  task automatic test_reset_mid_clear();
    int lows;
    bit done;
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    a_run_m = 0;
    repeat (10) tick();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'h55};
    a_rst = 1'b1;
    #2;
    total++;
    if (a_ready !== 1'b0 || a_rd_data !== 64'h0) begin
      bad++;
      $display("FAIL a_in_reset ready=%b rd=%h want=0/0", a_ready, a_rd_data);
    end
    tick();
    a_rst = 1'b0;
    lows = 0;
    done = 0;
    a_rd_addr = {5'd3, 5'd3};
    for (int c = 0; c < 100 && !done; c++) begin
      a_wr_en = (c < 20) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (a_ready === 1'b1) begin
        done = 1;
        a_wr_en = 2'b00;
        for (int r = 0; r < 32; r++) ma[r] = 32'h0;
        a_run_m = 1;
      end else lows++;
      tick();
    end
    total++;
    if (!done || lows != 31) begin
      bad++;
      $display("FAIL a_restart_clear_len got=%0d want=31 done=%0b", lows, done);
    end
    @(negedge clk);
    total++;
    if (a_rd_data[31:0] !== 32'h0 || a_regs !== '0) begin
      bad++;
      $display("FAIL a_x3_lost got=%h want=0", a_rd_data[31:0]);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a_run_m = 0;
    b_run_m = 0;
    for (int r = 0; r < 32; r++) ma[r] = 32'h0;
    for (int r = 0; r < 24; r++) mb[r] = 32'h0;
    a_rst = 1'b1; a_clear = 1'b0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_rst = 1'b1; b_clear = 1'b0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    test_reset();
    test_clear_b();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_invalid_addr();
    test_random();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
